mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single external word-granular memory port between the instruction cache (read-only) and the data cache (read/write-through).
- Grants per transaction with burst locking, so a 4-word line fill is not interleaved.
- Routes in-order read responses back to the issuing cache through a small source-tag FIFO.
- Sits between the two cache instances and the memory model / top-level memory pins.

Parameters:
- MAX_BURST, 4, max accepted beats per grant before forced re-arbitration (equals words per line).
- RD_DEPTH, 4, max outstanding reads tracked; power of two, at least 2.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_ic_ren  in  1  icache read request
- i_ic_addr  in  32  icache word address
- o_ic_ready  out  1  icache request accepted this cycle
- o_ic_rdata  out  32  icache read data
- o_ic_valid  out  1  icache read data valid
- i_dc_ren  in  1  dcache read request
- i_dc_wen  in  1  dcache write request; never asserted together with i_dc_ren
- i_dc_addr  in  32  dcache word address
- i_dc_wdata  in  32  dcache write data
- o_dc_ready  out  1  dcache request accepted this cycle
- o_dc_rdata  out  32  dcache read data
- o_dc_valid  out  1  dcache read data valid
- i_mem_ready  in  1  memory accepts a request this cycle
- o_mem_addr  out  32  memory address
- o_mem_ren  out  1  memory read
- o_mem_wen  out  1  memory write
- o_mem_wdata  out  32  memory write data
- i_mem_rdata  in  32  memory read data
- i_mem_valid  in  1  memory read data valid; in order, at least 1 cycle after acceptance
- o_err  out  1  sticky: response arrived with no outstanding read

Behaviour:
- Reset: i_rst async, active-high. Clears state to IDLE, beat count to 0, round-robin pointer to icache-last (dcache wins the first tie), tag FIFO empty, o_err to 0. All outputs are 0 during and after reset until a request arrives. Reset mid-burst abandons the burst; responses still in flight are dropped and flag o_err.
- Request signals: ic_req = i_ic_ren; dc_req = i_dc_ren | i_dc_wen.
- Grant (combinational, same-cycle pass-through, zero added latency):
  - BURST: owner = registered owner.
  - IDLE, one requester: grant it.
  - IDLE, both: grant the one not served last.
- Memory mux: o_mem_addr, o_mem_ren, o_mem_wen and o_mem_wdata come from the granted port. All are 0 when nothing is granted. Icache drives o_mem_wen = 0.
- Read blocking: a read is masked (ren to memory = 0) when the tag FIFO is full. Writes are never blocked by the FIFO.
- Acceptance: accept = granted request (after masking) & i_mem_ready. o_ic_ready / o_dc_ready = accept & owner matches the port.
- Accepted read: push source tag (SRC_I / SRC_D) into the FIFO.
- State machine:
  - IDLE: on accept, owner <= granted; count <= 1; go BURST unless MAX_BURST == 1. Update the round-robin pointer.
  - BURST, owner still requesting: on accept, count++. When count reaches MAX_BURST, go IDLE.
  - BURST, owner requests 0 this cycle: go IDLE. Another requester can win next cycle, not the same cycle.
  - BURST, owner requesting but memory not ready: hold owner, no count change.
- Responses: on i_mem_valid, pop the FIFO head. Pass i_mem_rdata to both o_ic_rdata and o_dc_rdata. Assert only the matching valid, same cycle (combinational).
  - Valid with an empty FIFO: both valids 0, set o_err.
- Simultaneous push and pop: occupancy unchanged, allowed even when full, because the pop frees a slot.
- FIFO pointers wrap modulo RD_DEPTH. Occupancy counter is clog2(RD_DEPTH)+1 bits.
- Write-then-read by the same owner within a burst is legal. Ordering is preserved by the memory.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_BURST}
  - src_t enum {SRC_I = 1'b0, SRC_D = 1'b1}
  - localparam default MAX_BURST, RD_DEPTH
- Sub-module mem_arb_tag_fifo: RD_DEPTH x 1-bit sync FIFO with async reset. Provides push, pop, head, full and empty; supports same-cycle push/pop when full.

Test Plan:
- Icache only: ic_ren with addr 0x100, 0x104, 0x108, 0x10C, ready=1, valid 2 cycles after each -> 4 o_ic_ready pulses, 4 o_ic_valid, o_dc_valid=0, back to IDLE after 4th beat.
- Contention: both request at cycle 0 after reset -> dcache granted (addr on o_mem_addr = i_dc_addr), icache o_ic_ready=0 until dcache burst of 4 ends. Next tie -> icache wins.
- Burst release: dcache does a single write (0x200, wdata 0xDEADBEEF), then drops wen while icache waits -> o_mem_wen=1 one cycle, icache granted the cycle after dcache deasserts.
- Backpressure: ready=0 for 3 cycles mid-burst -> owner held, count frozen, no readies; resumes on ready=1.
- FIFO full: 4 icache reads accepted, no valid returned -> 5th read masked (o_mem_ren=0). Valid plus new request in the same cycle -> accepted.
- Error and reset: i_mem_valid with empty FIFO -> o_err=1 and stays set. Assert i_rst mid-burst -> all outputs 0 immediately, o_err cleared.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_RD_DEPTH  = 4;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Source-tag FIFO: remembers which cache issued each outstanding read so the
// in-order responses can be steered back to the right requester.
module mem_arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  logic i_din,
    input  logic i_pop,
    output logic o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (cnt_q == CW'(DEPTH));
    assign o_empty = (cnt_q == '0);
    assign o_head  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_din;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single external memory port between icache and dcache with
// burst locking and round-robin tie breaking; routes read responses by tag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int RD_DEPTH  = DEF_RD_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ic_ren,
    input  logic [31:0] i_ic_addr,
    output logic        o_ic_ready,
    output logic [31:0] o_ic_rdata,
    output logic        o_ic_valid,
    input  logic        i_dc_ren,
    input  logic        i_dc_wen,
    input  logic [31:0] i_dc_addr,
    input  logic [31:0] i_dc_wdata,
    output logic        o_dc_ready,
    output logic [31:0] o_dc_rdata,
    output logic        o_dc_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_err
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q;
    src_t             owner_q;
    src_t             rr_last_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    logic ic_req;
    logic dc_req;
    logic gnt_vld;
    src_t gnt_src;
    logic gnt_ren;
    logic gnt_wen;
    logic accept;
    logic rd_push;
    logic rd_pop;
    logic fifo_head;
    logic fifo_full;
    logic fifo_empty;

    assign ic_req = i_ic_ren;
    assign dc_req = i_dc_ren | i_dc_wen;

    // Grant is held back while reset is asserted so every output stays low.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_src = SRC_I;
        if (!i_rst) begin
            if (state_q == ARB_BURST) begin
                gnt_src = owner_q;
                gnt_vld = (owner_q == SRC_I) ? ic_req : dc_req;
            end else if (ic_req && dc_req) begin
                gnt_vld = 1'b1;
                gnt_src = (rr_last_q == SRC_I) ? SRC_D : SRC_I;
            end else if (dc_req) begin
                gnt_vld = 1'b1;
                gnt_src = SRC_D;
            end else if (ic_req) begin
                gnt_vld = 1'b1;
                gnt_src = SRC_I;
            end
        end
    end

    assign gnt_ren = gnt_vld & ((gnt_src == SRC_I) ? i_ic_ren : i_dc_ren);
    assign gnt_wen = gnt_vld & (gnt_src == SRC_D) & i_dc_wen;
    assign rd_pop  = i_mem_valid & ~fifo_empty;

    assign o_mem_ren   = gnt_ren & (~fifo_full | rd_pop);
    assign o_mem_wen   = gnt_wen;
    assign o_mem_addr  = gnt_vld ? ((gnt_src == SRC_I) ? i_ic_addr : i_dc_addr) : 32'h0;
    assign o_mem_wdata = gnt_wen ? i_dc_wdata : 32'h0;

    assign accept     = (o_mem_ren | o_mem_wen) & i_mem_ready;
    assign rd_push    = accept & o_mem_ren;
    assign o_ic_ready = accept & (gnt_src == SRC_I);
    assign o_dc_ready = accept & (gnt_src == SRC_D);

    assign o_ic_valid = rd_pop & (fifo_head == SRC_I);
    assign o_dc_valid = rd_pop & (fifo_head == SRC_D);
    assign o_ic_rdata = (i_mem_valid && !i_rst) ? i_mem_rdata : 32'h0;
    assign o_dc_rdata = (i_mem_valid && !i_rst) ? i_mem_rdata : 32'h0;
    assign o_err      = err_q;

    mem_arb_tag_fifo #(
        .DEPTH (RD_DEPTH)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (rd_push),
        .i_din   (gnt_src),
        .i_pop   (rd_pop),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ARB_IDLE;
            owner_q   <= SRC_I;
            rr_last_q <= SRC_I;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (i_mem_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ARB_IDLE: begin
                    if (accept) begin
                        owner_q   <= gnt_src;
                        rr_last_q <= gnt_src;
                        count_q   <= CNT_W'(1);
                        if (MAX_BURST > 1) begin
                            state_q <= ARB_BURST;
                        end
                    end
                end
                ARB_BURST: begin
                    // Owner dropping its request releases the port for next cycle.
                    if (!gnt_vld) begin
                        state_q <= ARB_IDLE;
                        count_q <= '0;
                    end else if (accept) begin
                        if (count_q == CNT_W'(MAX_BURST - 1)) begin
                            state_q <= ARB_IDLE;
                            count_q <= '0;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scripted per-cycle stimulus with hand-worked expectations.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        ic_ren;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic [31:0] ic_rdata;
    logic        ic_valid;
    logic        dc_ren;
    logic        dc_wen;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_ready;
    logic [31:0] dc_rdata;
    logic        dc_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        err;

    int checks_cnt;
    int fail_cnt;

    mem_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ic_ren    (ic_ren),
        .i_ic_addr   (ic_addr),
        .o_ic_ready  (ic_ready),
        .o_ic_rdata  (ic_rdata),
        .o_ic_valid  (ic_valid),
        .i_dc_ren    (dc_ren),
        .i_dc_wen    (dc_wen),
        .i_dc_addr   (dc_addr),
        .i_dc_wdata  (dc_wdata),
        .o_dc_ready  (dc_ready),
        .o_dc_rdata  (dc_rdata),
        .o_dc_valid  (dc_valid),
        .i_mem_ready (mem_ready),
        .o_mem_addr  (mem_addr),
        .o_mem_ren   (mem_ren),
        .o_mem_wen   (mem_wen),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_valid (mem_valid),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end else begin
            $display("chk  %s got=%h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_icrdy"}, 32'(ic_ready), 32'd0);
        chk({tag, "_dcrdy"}, 32'(dc_ready), 32'd0);
        chk({tag, "_icvld"}, 32'(ic_valid), 32'd0);
        chk({tag, "_dcvld"}, 32'(dc_valid), 32'd0);
        chk({tag, "_mren"},  32'(mem_ren),  32'd0);
        chk({tag, "_mwen"},  32'(mem_wen),  32'd0);
        chk({tag, "_maddr"}, mem_addr,      32'd0);
        chk({tag, "_err"},   32'(err),      32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst = 1'b1; ic_ren = 0; ic_addr = 0; dc_ren = 0; dc_wen = 0;
        dc_addr = 0; dc_wdata = 0; mem_ready = 0; mem_rdata = 0; mem_valid = 0;
        #1;
        chk_all_zero("rst");
        tick();
        rst = 1'b0;

        // Icache-only 4-beat burst, data back two cycles after each beat
        for (int c = 0; c < 6; c++) begin
            ic_ren    = (c < 4);
            ic_addr   = 32'h100 + 32'(4 * c);
            mem_ready = 1'b1;
            mem_valid = (c >= 2);
            mem_rdata = 32'hA000_0000 + 32'(c);
            #1;
            chk("ic_rdy",   32'(ic_ready), 32'(c < 4));
            chk("ic_mren",  32'(mem_ren),  32'(c < 4));
            chk("ic_maddr", mem_addr,      (c < 4) ? 32'h100 + 32'(4 * c) : 32'h0);
            chk("ic_vld",   32'(ic_valid), 32'(c >= 2));
            chk("ic_dcvld", 32'(dc_valid), 32'd0);
            if (c >= 2) chk("ic_rdata", ic_rdata, 32'hA000_0000 + 32'(c));
            if (c == 4) chk("ic_idle", 32'(dut.state_q), 32'(ARB_IDLE));
            tick();
        end
        mem_valid = 0;

        // Contention right after reset: dcache wins, holds 4 beats, then icache
        rst = 1'b1; #1; rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            ic_ren   = 1'b1;
            ic_addr  = 32'h300;
            dc_wen   = 1'b1;
            dc_addr  = 32'h400 + 32'(4 * c);
            dc_wdata = 32'hD0 + 32'(c);
            #1;
            chk("ct_dcrdy", 32'(dc_ready), 32'(c < 4));
            chk("ct_icrdy", 32'(ic_ready), 32'(c == 4));
            chk("ct_maddr", mem_addr,      (c < 4) ? 32'h400 + 32'(4 * c) : 32'h300);
            chk("ct_mwen",  32'(mem_wen),  32'(c < 4));
            chk("ct_wdata", mem_wdata,     (c < 4) ? 32'hD0 + 32'(c) : 32'h0);
            chk("ct_mren",  32'(mem_ren),  32'(c == 4));
            tick();
        end
        ic_ren = 0; dc_wen = 0; mem_valid = 1; mem_rdata = 32'h55;
        #1;
        chk("ct_icvld", 32'(ic_valid), 32'd1);
        chk("ct_rdata", ic_rdata,      32'h55);
        chk("ct_dcvld", 32'(dc_valid), 32'd0);
        tick();
        mem_valid = 0;

        // Burst release: single dcache write, icache gets the port a cycle after
        dc_wen = 1; dc_addr = 32'h200; dc_wdata = 32'hDEADBEEF; ic_ren = 1; ic_addr = 32'h500;
        #1;
        chk("br_mwen",  32'(mem_wen),  32'd1);
        chk("br_wdata", mem_wdata,     32'hDEADBEEF);
        chk("br_maddr", mem_addr,      32'h200);
        chk("br_dcrdy", 32'(dc_ready), 32'd1);
        chk("br_icrdy", 32'(ic_ready), 32'd0);
        tick();
        dc_wen = 0;
        #1;
        chk("br_gap_icrdy", 32'(ic_ready), 32'd0);
        chk("br_gap_mwen",  32'(mem_wen),  32'd0);
        chk("br_gap_mren",  32'(mem_ren),  32'd0);
        tick();
        #1;
        chk("br_icrdy2", 32'(ic_ready), 32'd1);
        chk("br_maddr2", mem_addr,      32'h500);
        tick();

        // Backpressure mid-burst: owner held while dcache waits
        ic_addr = 32'h504; mem_ready = 0; dc_wen = 1; dc_addr = 32'h600; dc_wdata = 32'h1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_icrdy", 32'(ic_ready), 32'd0);
            chk("bp_dcrdy", 32'(dc_ready), 32'd0);
            chk("bp_maddr", mem_addr,      32'h504);
            tick();
        end
        mem_ready = 1;
        for (int c = 0; c < 3; c++) begin
            ic_addr = 32'h504 + 32'(4 * c);
            #1;
            chk("bp_res_icrdy", 32'(ic_ready), 32'd1);
            chk("bp_res_maddr", mem_addr,      32'h504 + 32'(4 * c));
            tick();
        end
        ic_addr = 32'h510;
        #1;
        chk("bp_end_dcrdy", 32'(dc_ready), 32'd1);
        chk("bp_end_icrdy", 32'(ic_ready), 32'd0);
        chk("bp_end_maddr", mem_addr,      32'h600);
        tick();

        // FIFO full: four icache reads outstanding, fifth is masked
        ic_ren = 0; dc_wen = 0;
        tick();
        ic_ren = 1; ic_addr = 32'h700;
        #1;
        chk("ff_mren",  32'(mem_ren),  32'd0);
        chk("ff_icrdy", 32'(ic_ready), 32'd0);
        chk("ff_maddr", mem_addr,      32'h700);
        tick();
        mem_valid = 1; mem_rdata = 32'h11;
        #1;
        chk("ff_pp_mren",  32'(mem_ren),  32'd1);
        chk("ff_pp_icrdy", 32'(ic_ready), 32'd1);
        chk("ff_pp_icvld", 32'(ic_valid), 32'd1);
        tick();
        ic_ren = 0;
        for (int c = 0; c < 4; c++) begin
            mem_rdata = 32'h20 + 32'(c);
            #1;
            chk("ff_drain_icvld", 32'(ic_valid), 32'd1);
            chk("ff_drain_rdata", ic_rdata,      32'h20 + 32'(c));
            tick();
        end

        // Response with nothing outstanding
        #1;
        chk("er_icvld", 32'(ic_valid), 32'd0);
        chk("er_dcvld", 32'(dc_valid), 32'd0);
        chk("er_pre",   32'(err),      32'd0);
        tick();
        mem_valid = 0;
        #1;
        chk("er_set", 32'(err), 32'd1);
        tick();
        dc_ren = 1; dc_addr = 32'h800;
        #1;
        chk("er_sticky", 32'(err),      32'd1);
        chk("dr_dcrdy",  32'(dc_ready), 32'd1);
        chk("dr_mren",   32'(mem_ren),  32'd1);
        chk("dr_maddr",  mem_addr,      32'h800);
        tick();
        dc_ren = 0; mem_valid = 1; mem_rdata = 32'h77;
        #1;
        chk("dr_dcvld", 32'(dc_valid), 32'd1);
        chk("dr_icvld", 32'(ic_valid), 32'd0);
        chk("dr_rdata", dc_rdata,      32'h77);
        tick();
        mem_valid = 0;

        // Reset in the middle of an icache burst
        ic_ren = 1; ic_addr = 32'h900;
        #1;
        chk("rb_icrdy", 32'(ic_ready), 32'd1);
        tick();
        ic_addr = 32'h904;
        #1;
        chk("rb_icrdy2", 32'(ic_ready), 32'd1);
        rst = 1;
        #1;
        chk_all_zero("rb_async");
        tick();
        chk_all_zero("rb_hold");
        rst = 0; ic_ren = 0; mem_valid = 1; mem_rdata = 32'h99;
        #1;
        chk("rb_drop_icvld", 32'(ic_valid), 32'd0);
        chk("rb_drop_dcvld", 32'(dc_valid), 32'd0);
        tick();
        mem_valid = 0;
        #1;
        chk("rb_err", 32'(err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
